// File: rtl/mem_request_queue_if.sv
// Host request/response and SDRAM-controller command signals for mem_request_queue.
// slave is the queue's view; master is the view of whatever drives the host side
// and models the controller.
interface mem_request_queue_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [24:0] req_addr;
  logic [15:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  logic        init_done;
  logic        err_sticky;

  logic [1:0]  mc_cmd;
  logic [24:0] mc_addr;
  logic [15:0] mc_wdata;
  logic [15:0] mc_rdata;
  logic        mc_ready;
  logic        mc_valid;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mc_rdata, mc_valid,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           init_done, err_sticky, mc_cmd, mc_addr, mc_wdata, mc_ready
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mc_rdata, mc_valid,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           init_done, err_sticky, mc_cmd, mc_addr, mc_wdata, mc_ready
  );
endinterface

// File: rtl/mem_request_queue.sv
// Host-side request queue in front of the SDRAM controller: buffers requests,
// issues them one at a time and returns a single-cycle response per request.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   INIT_WAIT | controller still initialising; requests queue up
//   IDLE      | controller free; pop the next request if one is queued
//   ISSUE     | mc_ready high for one cycle with the command presented
//   WAIT      | command held until completion pulse or timeout
module mem_request_queue #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_request_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_INIT_WAIT = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_ISSUE     = 2'd2;
  localparam logic [1:0] S_WAIT      = 2'd3;

  logic [1:0]       state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic             fifo_write [DEPTH];
  logic [24:0]      fifo_addr  [DEPTH];
  logic [15:0]      fifo_wdata [DEPTH];

  logic             hold_write;
  logic [TMO_W-1:0] tmo_cnt;

  logic             init_done_r;
  logic             err_sticky_r;
  logic             rsp_valid_r;
  logic             rsp_write_r;
  logic [15:0]      rsp_rdata_r;
  logic             rsp_err_r;
  logic [1:0]       mc_cmd_r;
  logic [24:0]      mc_addr_r;
  logic [15:0]      mc_wdata_r;
  logic             mc_ready_r;

  // No bypass: a full FIFO refuses even when a pop happens the same cycle.
  assign full          = (count == (PTR_W+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.req_ready = !full && !rst;
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = (state == S_IDLE) && !empty;

  assign bus.init_done  = init_done_r;
  assign bus.err_sticky = err_sticky_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_write  = rsp_write_r;
  assign bus.rsp_rdata  = rsp_rdata_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.mc_cmd     = mc_cmd_r;
  assign bus.mc_addr    = mc_addr_r;
  assign bus.mc_wdata   = mc_wdata_r;
  assign bus.mc_ready   = mc_ready_r;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.req_write;
      fifo_addr[wr_ptr]  <= bus.req_addr;
      fifo_wdata[wr_ptr] <= bus.req_wdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: issue one request at a time, hold the command, report the outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT_WAIT;
      hold_write   <= 1'b0;
      tmo_cnt      <= '0;
      init_done_r  <= 1'b0;
      err_sticky_r <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_write_r  <= 1'b0;
      rsp_rdata_r  <= '0;
      rsp_err_r    <= 1'b0;
      mc_cmd_r     <= 2'b00;
      mc_addr_r    <= '0;
      mc_wdata_r   <= '0;
      mc_ready_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (bus.mc_valid) begin
            init_done_r <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!empty) begin
            hold_write <= fifo_write[rd_ptr];
            mc_addr_r  <= fifo_addr[rd_ptr];
            mc_wdata_r <= fifo_wdata[rd_ptr];
            mc_cmd_r   <= fifo_write[rd_ptr] ? 2'b10 : 2'b01;
            mc_ready_r <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mc_ready_r <= 1'b0;
          tmo_cnt    <= TMO_W'(TIMEOUT_CYCLES - 1);
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the last allowed cycle still counts as a completion.
          if (bus.mc_valid) begin
            rsp_valid_r <= 1'b1;
            rsp_write_r <= hold_write;
            rsp_rdata_r <= hold_write ? 16'h0000 : bus.mc_rdata;
            rsp_err_r   <= 1'b0;
            mc_cmd_r    <= 2'b00;
            state       <= S_IDLE;
          end else if (tmo_cnt == '0) begin
            rsp_valid_r  <= 1'b1;
            rsp_write_r  <= hold_write;
            rsp_rdata_r  <= 16'h0000;
            rsp_err_r    <= 1'b1;
            err_sticky_r <= 1'b1;
            mc_cmd_r     <= 2'b00;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        default: state <= S_INIT_WAIT;
      endcase
    end
  end

endmodule
